// File: rtl/iter_mult_pkg.sv
// Shared types for the iterative multiplier: op encoding, FSM states and
// helpers that decide which operands are interpreted as signed.
package iter_mult_pkg;

    typedef enum logic [1:0] {
        OP_UU  = 2'b00,
        OP_SS  = 2'b01,
        OP_SU  = 2'b10,
        OP_RSV = 2'b11
    } mult_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mult_state_e;

    localparam logic [1:0] OP_CODE_UU = 2'b00;
    localparam logic [1:0] OP_CODE_SS = 2'b01;
    localparam logic [1:0] OP_CODE_SU = 2'b10;

    // The reserved encoding falls through to unsigned x unsigned.
    function automatic logic mcand_is_signed(input logic [1:0] op);
        return (op == OP_CODE_SS) || (op == OP_CODE_SU);
    endfunction

    function automatic logic mplier_is_signed(input logic [1:0] op);
        return (op == OP_CODE_SS);
    endfunction

endpackage

// File: rtl/iter_mult_step.sv
// Combinational STEP-bit shift-add stage: adds the pre-shifted multiplicand
// into the accumulator once for every set bit of the current multiplier digit.
module iter_mult_step
    import iter_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [STEP-1:0]    bits,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] partial [STEP+1];

    assign partial[0] = acc;

    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_bit
            assign partial[gi+1] = partial[gi] + (bits[gi] ? (mcand << gi) : '0);
        end
    endgenerate

    assign acc_next = partial[STEP];

endmodule

// File: rtl/iter_seq_multiplier.sv
// Iterative shift-add multiplier retiring STEP multiplier bits per cycle on
// operand magnitudes, with a final conditional negate. Define
// ITER_MULT_EARLY_OUT_EN to finish as soon as no multiplier bits remain.
module iter_seq_multiplier
    import iter_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     mplier,
    input  logic [WIDTH-1:0]     mcand,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_valid,
    output logic                 stall
);

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CNT_W  = $clog2(NSTEPS + 1);

    generate
        if ((WIDTH % STEP != 0) || !(STEP == 1 || STEP == 2 || STEP == 4) ||
            (WIDTH < 8) || (WIDTH > 64)) begin : g_bad_cfg
            $error("iter_seq_multiplier: unsupported WIDTH/STEP combination");
        end
    endgenerate

    mult_state_e          state_reg, state_next;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic                 neg_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2*WIDTH-1:0]   product_reg;

    logic                 mcand_neg, mplier_neg;
    logic [WIDTH-1:0]     mcand_mag, mplier_mag;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 finish;

    assign mcand_neg  = mcand_is_signed(op) && mcand[WIDTH-1];
    assign mplier_neg = mplier_is_signed(op) && mplier[WIDTH-1];
    // The magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
    assign mcand_mag  = mcand_neg  ? -mcand  : mcand;
    assign mplier_mag = mplier_neg ? -mplier : mplier;

    iter_mult_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc      (acc_reg),
        .mcand    (mcand_reg),
        .bits     (mplier_reg[STEP-1:0]),
        .acc_next (acc_next)
    );

`ifdef ITER_MULT_EARLY_OUT_EN
    logic [WIDTH-1:0] remaining;
    assign remaining = mplier_reg >> STEP;
    assign finish    = (cnt_reg == CNT_W'(1)) || (remaining == '0);
`else
    assign finish    = (cnt_reg == CNT_W'(1));
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid) state_next = ST_CALC;
            ST_CALC: if (finish)   state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            neg_reg     <= 1'b0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && in_valid) begin
                acc_reg    <= '0;
                mcand_reg  <= {{WIDTH{1'b0}}, mcand_mag};
                mplier_reg <= mplier_mag;
                neg_reg    <= mcand_neg ^ mplier_neg;
                cnt_reg    <= CNT_W'(NSTEPS);
            end else if (state_reg == ST_CALC) begin
                acc_reg    <= acc_next;
                mcand_reg  <= mcand_reg << STEP;
                mplier_reg <= mplier_reg >> STEP;
                if (finish) begin
                    cnt_reg     <= '0;
                    product_reg <= neg_reg ? -acc_next : acc_next;
                end else begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end
        end
    end

    assign product   = product_reg;
    assign out_valid = (state_reg == ST_DONE);
    // Reset gating keeps stall low while rst_n is asserted even if in_valid is high.
    assign stall     = rst_n && ((state_reg == ST_CALC) || (state_reg == ST_IDLE && in_valid));

endmodule

// File: tb/tb_iter_seq_multiplier.sv
// Scoreboard bench for iter_seq_multiplier: one WIDTH=32 instance with STEP=1
// and one with STEP=4, sharing clock and reset.
module tb_iter_seq_multiplier;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          iv1, iv4;
    logic [1:0]    op1, op4;
    logic [W-1:0]  mp1, mp4, mc1, mc4;
    logic [2*W-1:0] pr1, pr4;
    logic          ov1, ov4, st1, st4;

    iter_seq_multiplier #(.WIDTH(W), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .op(op1), .mplier(mp1),
        .mcand(mc1), .product(pr1), .out_valid(ov1), .stall(st1)
    );

    iter_seq_multiplier #(.WIDTH(W), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .op(op4), .mplier(mp4),
        .mcand(mc4), .product(pr4), .out_valid(ov4), .stall(st4)
    );

    typedef struct {
        logic [2*W-1:0] prod;
        int             acc;
        int             lat;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [2*W-1:0] last1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model_prod(input logic [1:0] op, input logic [W-1:0] mc,
                                                  input logic [W-1:0] mp);
        logic [2*W-1:0] a, b;
        case (op)
            2'b01: begin a = {{W{mc[W-1]}}, mc}; b = {{W{mp[W-1]}}, mp}; end
            2'b10: begin a = {{W{mc[W-1]}}, mc}; b = {{W{1'b0}}, mp}; end
            default: begin a = {{W{1'b0}}, mc}; b = {{W{1'b0}}, mp}; end
        endcase
        return a * b;
    endfunction

    function automatic int model_lat(input int step, input logic [1:0] op, input logic [W-1:0] mp);
        logic [W-1:0] mag;
        int n;
        mag = (op == 2'b01 && mp[W-1]) ? (~mp + 1) : mp;
`ifdef ITER_MULT_EARLY_OUT_EN
        n = 1;
        mag = mag >> step;
        while (mag != 0) begin
            n++;
            mag = mag >> step;
        end
`else
        n = W / step;
`endif
        return n;
    endfunction

    always @(negedge clk) begin : mon1
        exp_t e;
        if (ov1) begin
            if (q1.size() == 0) check("dut1_spurious_out_valid", {63'b0, ov1}, 64'd0);
            else begin
                e = q1.pop_front();
                check("dut1_product", pr1, e.prod);
                check("dut1_latency", 64'(cyc - e.acc), 64'(e.lat));
                last1 = e.prod;
                $display("dut1 result %h latency %0d", pr1, cyc - e.acc);
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (ov4) begin
            if (q4.size() == 0) check("dut4_spurious_out_valid", {63'b0, ov4}, 64'd0);
            else begin
                e = q4.pop_front();
                check("dut4_product", pr4, e.prod);
                check("dut4_latency", 64'(cyc - e.acc), 64'(e.lat));
                $display("dut4 result %h latency %0d", pr4, cyc - e.acc);
            end
        end
    end

    task automatic drive(input int which, input logic [1:0] op, input logic [W-1:0] mc,
                         input logic [W-1:0] mp, input bit push);
        exp_t e;
        if (which == 1) begin iv1 = 1'b1; op1 = op; mc1 = mc; mp1 = mp; end
        else            begin iv4 = 1'b1; op4 = op; mc4 = mc; mp4 = mp; end
        @(posedge clk);
        #1;
        e.prod = model_prod(op, mc, mp);
        e.acc  = cyc;
        e.lat  = model_lat(which == 1 ? 1 : 4, op, mp);
        if (push) begin
            if (which == 1) q1.push_back(e); else q4.push_back(e);
        end
        if (which == 1) begin iv1 = 1'b0; mc1 = $urandom; mp1 = $urandom; op1 = 2'($urandom); end
        else            begin iv4 = 1'b0; mc4 = $urandom; mp4 = $urandom; op4 = 2'($urandom); end
    endtask

    task automatic wait_done(input int which);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (which == 1 && q1.size() == 0) return;
            if (which == 4 && q4.size() == 0) return;
        end
        if (which == 1) begin check("dut1_timeout_pending", 64'(q1.size()), 64'd0); q1.delete(); end
        else            begin check("dut4_timeout_pending", 64'(q4.size()), 64'd0); q4.delete(); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    logic [1:0]   tbl_op [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
    logic [W-1:0] tbl_mc [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [W-1:0] tbl_mp [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd2};

    initial begin
        rst_n = 1'b0;
        iv1 = 0; iv4 = 0; op1 = 0; op4 = 0; mp1 = 0; mp4 = 0; mc1 = 0; mc4 = 0;
        last1 = '0;
        #12;
        check("rst_product1", pr1, 64'd0);
        check("rst_product4", pr4, 64'd0);
        check("rst_out_valid1", {63'b0, ov1}, 64'd0);
        iv1 = 1'b1;
        #1;
        check("rst_stall1_in_valid", {63'b0, st1}, 64'd0);
        iv1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 3 x 5, stall behaviour through IDLE/CALC and product hold
        iv1 = 1'b1;
        #1;
        check("stall_idle_in_valid", {63'b0, st1}, 64'd1);
        drive(1, 2'b00, 32'd5, 32'd3, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_calc", {63'b0, st1}, 64'd1);
        end
        wait_done(1);
        @(negedge clk);
        @(negedge clk);
        check("stall_idle_quiet", {63'b0, st1}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("product_hold", pr1, last1);
        end

        // signed/unsigned corner operands on both step sizes
        for (int i = 0; i < 4; i++) begin
            drive(1, tbl_op[i], tbl_mc[i], tbl_mp[i], 1);
            wait_done(1);
            drive(4, tbl_op[i], tbl_mc[i], tbl_mp[i], 1);
            wait_done(4);
        end

        // STEP=4: 7 x 9 with in_valid pulses during CALC ignored
        drive(4, 2'b00, 32'd7, 32'd9, 1);
        @(negedge clk);
        iv4 = 1'b1; op4 = 2'b01; mc4 = 32'hFFFF_FFFF; mp4 = 32'h8000_0000;
        @(negedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        wait_done(4);

        // multiplier of 1: shortest latency when early-out is built in
        drive(1, 2'b00, 32'd123, 32'd1, 1);
        wait_done(1);

        // back-to-back: 2x3 then 4x5 accepted in the cycle after out_valid
        drive(1, 2'b00, 32'd2, 32'd3, 1);
        begin : b2b
            bit seen;
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                seen = ov1;
            end
            check("b2b_first_out_valid", {63'b0, ov1}, 64'd1);
        end
        @(posedge clk);
        #1;
        drive(1, 2'b00, 32'd4, 32'd5, 1);
        wait_done(1);

        // random operands including the reserved op encoding
        for (int i = 0; i < 16; i++) begin
            drive(1, 2'($urandom_range(0, 3)), $urandom, (i % 2) ? $urandom : 32'($urandom_range(0, 255)), 1);
            wait_done(1);
            drive(4, 2'($urandom_range(0, 3)), $urandom, (i % 2) ? $urandom : 32'($urandom_range(0, 255)), 1);
            wait_done(4);
        end

        // asynchronous reset in CALC cycle 10 aborts without a result
        drive(1, 2'b00, 32'h1234_5678, 32'h8765_4321, 0);
        repeat (9) @(posedge clk);
        #2;
        check("abort_pre_product_nonzero", {63'b0, (pr1 != 0)}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_product", pr1, 64'd0);
        check("abort_out_valid", {63'b0, ov1}, 64'd0);
        check("abort_stall", {63'b0, st1}, 64'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        drive(1, 2'b00, 32'd2, 32'd2, 1);
        wait_done(1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
